// File: rtl/hms_time_ctrl_if.sv
// Button, tick and count-enable bundle between the HMS counters/panel and hms_time_ctrl.
// The slave modport is the controller side; the master modport is the side that owns the counters.
interface hms_time_ctrl_if;
  logic       i_tick_1hz;
  logic       i_sec_max;
  logic       i_min_max;
  logic       i_sw0;
  logic       i_sw1;
  logic       i_sw2;
  logic       o_mode;
  logic [1:0] o_position;
  logic       o_sec_inc;
  logic       o_min_inc;
  logic       o_hour_inc;
  logic [5:0] o_blank;

  modport master (
    output i_tick_1hz, i_sec_max, i_min_max, i_sw0, i_sw1, i_sw2,
    input  o_mode, o_position, o_sec_inc, o_min_inc, o_hour_inc, o_blank
  );

  modport slave (
    input  i_tick_1hz, i_sec_max, i_min_max, i_sw0, i_sw1, i_sw2,
    output o_mode, o_position, o_sec_inc, o_min_inc, o_hour_inc, o_blank
  );
endinterface

// File: rtl/hms_time_ctrl.sv
// HMS clock sequencer: button debounce, CLOCK/SETUP mode FSM, count enables and digit blink.
// Define HMS_TIME_CTRL_AUTOREPEAT_EN to enable sw2 auto-repeat while in SETUP.
module hms_time_ctrl #(
  parameter int DEB_CNT   = 500000,
  parameter int BLINK_DIV = 25000000,
  parameter int RPT_DLY   = 50000000,
  parameter int RPT_PER   = 12500000
) (
  input  logic           clk,
  input  logic           rst,
  hms_time_ctrl_if.slave bus
);

  localparam int DEB_W   = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CNT - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic {ST_CLOCK = 1'b0, ST_SETUP = 1'b1} state_t;
  typedef enum logic [1:0] {POS_SEC = 2'd0, POS_MIN = 2'd1, POS_HOUR = 2'd2} pos_t;

  if (DEB_CNT < 1 || BLINK_DIV < 1 || RPT_DLY < 1 || RPT_PER < 1) begin : g_bad_param
    $error("hms_time_ctrl: timing parameters must all be at least 1");
  end

  // ---------------------------------------------------------------- buttons
  logic [2:0]       w_sw_raw;
  logic [2:0]       r_sync0, r_sync1, r_deb;
  logic [DEB_W-1:0] r_deb_cnt [3];
  logic [2:0]       w_deb_flip, w_press;

  assign w_sw_raw = {bus.i_sw2, bus.i_sw1, bus.i_sw0};

  // NOTE: every variable driven here gets a value before any branch, so no latch is inferred.
  always_comb begin
    w_deb_flip = '0;
    w_press    = '0;
    for (int i = 0; i < 3; i++) begin
      w_deb_flip[i] = (r_sync1[i] != r_deb[i]) && (r_deb_cnt[i] == DEB_LAST);
      w_press[i]    = w_deb_flip[i] && !r_sync1[i];
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0 <= '1;
      r_sync1 <= '1;
      r_deb   <= '1;
      // NOTE: these counters are plain flops, not a RAM, so clearing them in reset is fine.
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync0 <= w_sw_raw;
      r_sync1 <= r_sync0;
      for (int i = 0; i < 3; i++) begin
        if (r_sync1[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (w_deb_flip[i]) begin
          r_deb[i]     <= r_sync1[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- mode FSM
  state_t r_state, w_state_nxt;
  pos_t   r_pos, w_pos_nxt;
  logic   r_sec_inc, r_min_inc, r_hour_inc;
  logic   w_sec_nxt, w_min_nxt, w_hour_nxt;
  logic   w_blink_clr;
  logic   w_rpt_pulse;
  logic   w_rpting_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_sec_nxt   = 1'b0;
    w_min_nxt   = 1'b0;
    w_hour_nxt  = 1'b0;
    w_blink_clr = 1'b0;
    unique case (r_state)
      ST_CLOCK: begin
        w_sec_nxt  = bus.i_tick_1hz;
        w_min_nxt  = bus.i_tick_1hz & bus.i_sec_max;
        w_hour_nxt = bus.i_tick_1hz & bus.i_sec_max & bus.i_min_max;
        if (w_press[0]) begin
          w_state_nxt = ST_SETUP;
          w_pos_nxt   = POS_SEC;
          w_blink_clr = 1'b1;
        end
      end
      ST_SETUP: begin
        // sw0 wins a same-cycle tie; sw1/sw2 are only looked at without it.
        if (w_press[0]) begin
          w_state_nxt = ST_CLOCK;
        end else begin
          if (w_press[1]) begin
            w_blink_clr = 1'b1;
            case (r_pos)
              POS_SEC: w_pos_nxt = POS_MIN;
              POS_MIN: w_pos_nxt = POS_HOUR;
              default: w_pos_nxt = POS_SEC;
            endcase
          end
          if (w_press[2] || w_rpt_pulse) begin
            case (r_pos)
              POS_SEC: w_sec_nxt  = 1'b1;
              POS_MIN: w_min_nxt  = 1'b1;
              default: w_hour_nxt = 1'b1;
            endcase
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------- auto-repeat
`ifdef HMS_TIME_CTRL_AUTOREPEAT_EN
  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(RPT_DLY - 1);
  localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(RPT_PER - 1);

  logic             r_rpt_arm, r_rpting, w_rpt_arm_nxt, w_rpt_hold;
  logic [RPT_W-1:0] r_rpt_cnt, w_rpt_cnt_nxt;

  always_comb begin
    w_rpt_arm_nxt = r_rpt_arm;
    w_rpting_nxt  = r_rpting;
    w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
    w_rpt_pulse   = 1'b0;
    w_rpt_hold    = r_rpt_arm && (r_state == ST_SETUP) && !r_deb[2] && !w_press[0] && !w_press[1];
    if ((r_state == ST_SETUP) && w_press[2] && !w_press[0] && !w_press[1]) begin
      w_rpt_arm_nxt = 1'b1;
      w_rpting_nxt  = 1'b0;
      w_rpt_cnt_nxt = '0;
    end else if (!w_rpt_hold) begin
      w_rpt_arm_nxt = 1'b0;
      w_rpting_nxt  = 1'b0;
      w_rpt_cnt_nxt = '0;
    end else if (r_rpt_cnt == (r_rpting ? RPT_PER_LAST : RPT_DLY_LAST)) begin
      w_rpt_pulse   = 1'b1;
      w_rpting_nxt  = 1'b1;
      w_rpt_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rpt_arm <= 1'b0;
      r_rpting  <= 1'b0;
      r_rpt_cnt <= '0;
    end else begin
      r_rpt_arm <= w_rpt_arm_nxt;
      r_rpting  <= w_rpting_nxt;
      r_rpt_cnt <= w_rpt_cnt_nxt;
    end
  end
`else
  assign w_rpt_pulse  = 1'b0;
  assign w_rpting_nxt = 1'b0;
`endif

  // ---------------------------------------------------------------- blink
  logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_nxt;
  logic               r_phase, w_phase_nxt;
  logic [5:0]         r_blank, w_blank_nxt;

  always_comb begin
    w_blink_cnt_nxt = r_blink_cnt + 1'b1;
    w_phase_nxt     = r_phase;
    if (w_blink_clr) begin
      w_blink_cnt_nxt = '0;
      w_phase_nxt     = 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      w_blink_cnt_nxt = '0;
      w_phase_nxt     = ~r_phase;
    end
  end

  // Mask is built from next-state values so it lines up with the registered mode/position.
  always_comb begin
    w_blank_nxt = 6'h00;
    if ((w_state_nxt == ST_SETUP) && w_phase_nxt && !w_rpting_nxt) begin
      case (w_pos_nxt)
        POS_SEC: w_blank_nxt = 6'b000011;
        POS_MIN: w_blank_nxt = 6'b001100;
        default: w_blank_nxt = 6'b110000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_CLOCK;
      r_pos       <= POS_SEC;
      r_sec_inc   <= 1'b0;
      r_min_inc   <= 1'b0;
      r_hour_inc  <= 1'b0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_blank     <= 6'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_pos       <= w_pos_nxt;
      r_sec_inc   <= w_sec_nxt;
      r_min_inc   <= w_min_nxt;
      r_hour_inc  <= w_hour_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_blank     <= w_blank_nxt;
    end
  end

  assign bus.o_mode     = (r_state == ST_SETUP);
  assign bus.o_position = r_pos;
  assign bus.o_sec_inc  = r_sec_inc;
  assign bus.o_min_inc  = r_min_inc;
  assign bus.o_hour_inc = r_hour_inc;
  assign bus.o_blank    = r_blank;

endmodule

// File: tb/tb_hms_time_ctrl.sv
// Directed bench for hms_time_ctrl with short debounce/blink/repeat timings.
// Expected values are hand-derived; outputs are sampled 1 ns after the rising edge.
module tb_hms_time_ctrl;
  localparam int DEB_CNT   = 4;
  localparam int BLINK_DIV = 8;
  localparam int RPT_DLY   = 20;
  localparam int RPT_PER   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hms_time_ctrl_if bus ();

  hms_time_ctrl #(
    .DEB_CNT  (DEB_CNT),
    .BLINK_DIV(BLINK_DIV),
    .RPT_DLY  (RPT_DLY),
    .RPT_PER  (RPT_PER)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] incs();
    return {5'd0, bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic hour_exp;
    bus.i_tick_1hz = 1'b0;
    bus.i_sec_max  = 1'b0;
    bus.i_min_max  = 1'b0;
    bus.i_sw0      = 1'b1;
    bus.i_sw1      = 1'b1;
    bus.i_sw2      = 1'b1;

    // Reset values while rst is held
    #12;
    check("rst_mode", bus.o_mode, 1'b0);
    check("rst_pos", bus.o_position, 2'd0);
    check("rst_incs", incs(), 8'h0);
    check("rst_blank", bus.o_blank, 6'h00);
    step(1);
    rst = 1'b0;
    step(2);

    // CLOCK mode ticks with carry
    bus.i_tick_1hz = 1'b1; bus.i_sec_max = 1'b1; bus.i_min_max = 1'b1;
    step(1);
    check("tick_carry_all", incs(), 8'b111);
    bus.i_tick_1hz = 1'b0;
    step(1);
    check("tick_one_cycle", incs(), 8'b000);
    bus.i_tick_1hz = 1'b1; bus.i_min_max = 1'b0;
    step(1);
    check("tick_carry_min", incs(), 8'b110);
    bus.i_sec_max = 1'b0; bus.i_min_max = 1'b1;
    step(1);
    check("tick_sec_only", incs(), 8'b100);
    bus.i_tick_1hz = 1'b0; bus.i_sec_max = 1'b0; bus.i_min_max = 1'b0;
    step(1);

    // sw2 ignored in CLOCK
    bus.i_sw2 = 1'b0;
    step(7);
    check("clock_sw2_ignored", incs(), 8'b000);
    bus.i_sw2 = 1'b1;
    step(8);

    // 3-cycle glitch on sw0 is rejected
    bus.i_sw0 = 1'b0;
    step(3);
    bus.i_sw0 = 1'b1;
    step(8);
    check("glitch_no_mode", bus.o_mode, 1'b0);

    // Real press: mode flips on edge 6 (2 sync + 4 debounce)
    bus.i_sw0 = 1'b0;
    step(5);
    check("deb_not_yet", bus.o_mode, 1'b0);
    step(1);
    check("setup_entry_mode", bus.o_mode, 1'b1);
    check("setup_entry_pos", bus.o_position, 2'd0);
    check("setup_entry_blank", bus.o_blank, 6'h00);
    step(4);
    bus.i_sw0 = 1'b1;
    step(3);
    check("blink_sec_e7", bus.o_blank, 6'h00);
    step(1);
    check("blink_sec_e8", bus.o_blank, 6'h03);
    step(7);
    check("blink_sec_e15", bus.o_blank, 6'h03);
    step(1);
    check("blink_sec_e16", bus.o_blank, 6'h00);
    check("release_no_event", bus.o_mode, 1'b1);

    // Ticks are ignored in SETUP
    bus.i_tick_1hz = 1'b1; bus.i_sec_max = 1'b1; bus.i_min_max = 1'b1;
    step(2);
    check("setup_tick_ignored", incs(), 8'b000);
    bus.i_tick_1hz = 1'b0;
    step(1);

    // Position stepping, with blink restart on change
    bus.i_sw1 = 1'b0;
    step(6);
    check("pos_min", bus.o_position, 2'd1);
    check("pos_change_blank", bus.o_blank, 6'h00);
    bus.i_sw1 = 1'b1;
    step(7);
    check("blink_min_hold", bus.o_blank, 6'h00);
    step(1);
    check("blink_min_on", bus.o_blank, 6'h0C);
    bus.i_sw1 = 1'b0;
    step(6);
    check("pos_hour", bus.o_position, 2'd2);
    bus.i_sw1 = 1'b1;
    step(8);
    check("blink_hour_on", bus.o_blank, 6'h30);
    bus.i_sw1 = 1'b0;
    step(6);
    check("pos_wrap_sec", bus.o_position, 2'd0);
    bus.i_sw1 = 1'b1;
    step(8);
    bus.i_sw1 = 1'b0;
    step(6);
    check("pos_min_again", bus.o_position, 2'd1);
    bus.i_sw1 = 1'b1;
    step(8);

    // sw2 at MIN: single minutes pulse, ticks ignored meanwhile
    bus.i_tick_1hz = 1'b1; bus.i_sec_max = 1'b1; bus.i_min_max = 1'b1;
    bus.i_sw2 = 1'b0;
    step(5);
    check("sw2_pre", incs(), 8'b000);
    step(1);
    check("sw2_min_only", incs(), 8'b010);
    step(1);
    check("sw2_single", incs(), 8'b000);
    bus.i_tick_1hz = 1'b0;
    bus.i_sw2 = 1'b1;
    step(8);
    check("sw2_release_quiet", incs(), 8'b000);

    // sw0 + sw1 in the same cycle at MIN, with a tick: leave SETUP, keep MIN, drop tick
    bus.i_tick_1hz = 1'b1;
    bus.i_sw0 = 1'b0; bus.i_sw1 = 1'b0;
    step(6);
    check("tie_mode", bus.o_mode, 1'b0);
    check("tie_pos_held", bus.o_position, 2'd1);
    check("tie_tick_dropped", incs(), 8'b000);
    check("tie_blank", bus.o_blank, 6'h00);
    bus.i_tick_1hz = 1'b0;
    bus.i_sw0 = 1'b1; bus.i_sw1 = 1'b1;
    step(8);

    // Reset mid-debounce while in SETUP/MIN
    bus.i_sw0 = 1'b0;
    step(6);
    bus.i_sw0 = 1'b1;
    step(8);
    bus.i_sw1 = 1'b0;
    step(6);
    bus.i_sw1 = 1'b1;
    step(8);
    check("pre_rst_pos", bus.o_position, 2'd1);
    bus.i_sw0 = 1'b0;
    step(4);
    rst = 1'b1;
    #1;
    check("midrst_mode", bus.o_mode, 1'b0);
    check("midrst_pos", bus.o_position, 2'd0);
    check("midrst_incs", incs(), 8'b000);
    check("midrst_blank", bus.o_blank, 6'h00);
    step(1);
    bus.i_sw0 = 1'b1;
    rst = 1'b0;
    step(10);
    check("no_press_after_rst", bus.o_mode, 1'b0);

    // Hold sw2 at HOUR for 40 cycles
    bus.i_sw0 = 1'b0;
    step(6);
    bus.i_sw0 = 1'b1;
    step(8);
    bus.i_sw1 = 1'b0;
    step(6);
    bus.i_sw1 = 1'b1;
    step(8);
    bus.i_sw1 = 1'b0;
    step(6);
    bus.i_sw1 = 1'b1;
    step(8);
    check("hold_pos_hour", bus.o_position, 2'd2);
    bus.i_sw2 = 1'b0;
    for (int i = 1; i <= 56; i++) begin
      step(1);
`ifdef HMS_TIME_CTRL_AUTOREPEAT_EN
      hour_exp = (i == 6) || (i >= 26 && i <= 46 && ((i - 26) % 5) == 0);
      if (i == 30) check("rpt_blank_visible", bus.o_blank, 6'h00);
`else
      hour_exp = (i == 6);
`endif
      check($sformatf("hold_c%0d", i), incs(), {7'd0, hour_exp});
      if (i == 40) bus.i_sw2 = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
